bsg_mem_nr1w_one_hot_mask_write_bit_sync: RTL and testbench
===========================================================

Name: bsg_mem_nr1w_one_hot_mask_write_bit_sync

Overview:
- Register-file memory: one write port, read_ports_p read ports, all addressed one-hot (zero-hot is legal and means idle).
- Per-bit write mask; per-entry valid bits with a one-hot clear; each read port returns data and the entry valid bit with one-cycle registered latency.
- Optional write-to-read bypass.
- Used for small tag/metadata arrays in cache and network controllers, where a sync-read, flop-based store with invalidate is needed.

Parameters:
- width_p, (none, must be set), data bits per entry.
- els_p, (none, must be set), number of entries; 0 is legal (safe_els_lp = max(els_p,1)).
- read_ports_p, 1, number of independent read ports; must be >= 1.
- write_bypass_p, 0, 1 = a read hitting the entry written in the same cycle returns the post-write value; 0 = it returns the pre-write value.
- hold_read_p, 1, 1 = r_data_o/r_entry_v_o hold the last value when a port's r_v_i is zero-hot; 0 = they go to 0.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- w_v_i  input  safe_els_lp  one/zero-hot write select.
- w_data_i  input  width_p  write data.
- w_mask_i  input  width_p  bit j written only when w_mask_i[j]=1.
- clear_v_i  input  safe_els_lp  one/zero-hot entry invalidate.
- r_v_i  input  read_ports_p*safe_els_lp  per-port one/zero-hot read select.
- r_data_o  output  read_ports_p*width_p  per-port registered read data.
- r_entry_v_o  output  read_ports_p  per-port registered valid bit of the entry read.
- r_v_o  output  read_ports_p  1 in the cycle after a port's r_v_i was non-zero.

Behaviour:
- Reset (synchronous, active-high): on a clk_i edge with reset_i=1, all data bits, all valid bits, r_data_o, r_entry_v_o and r_v_o go to 0. Writes, clears and reads presented during reset are ignored.
- Write: on the edge where w_v_i[i]=1, data[i][j] <= w_data_i[j] where w_mask_i[j]=1; unmasked bits are unchanged. valid[i] <= 1 regardless of mask value (an all-zero mask still validates).
- Clear: clear_v_i[i]=1 sets valid[i] <= 0; data is untouched.
- Write and clear to the same entry in the same cycle: the write wins and valid[i]=1. Write and clear to different entries: both take effect.
- Read latency is 1 cycle. If port p has r_v_i[p]=entry i at edge t, then after edge t: r_data_o[p] = data[i], r_entry_v_o[p] = valid[i], r_v_o[p]=1.
- Read/write collision, same entry, same cycle:
  - write_bypass_p=1: r_data_o is the masked merge of old data and w_data_i; r_entry_v_o=1.
  - write_bypass_p=0: r_data_o is the old data and r_entry_v_o is the old valid.
- Read/clear collision, same entry: bypass=1 gives r_entry_v_o=0 unless a write to that entry is also present; bypass=0 gives the old valid.
- Idle port (zero-hot r_v_i[p]): r_v_o[p]=0. r_data_o and r_entry_v_o hold (hold_read_p=1) or go to 0 (hold_read_p=0).
- Multiple ports may read the same entry in the same cycle; all receive identical values.
- els_p=0: no storage; r_data_o and r_entry_v_o are always 0, and r_v_o still tracks r_v_i (which is always 0).
- Simulation only:
  - error if w_v_i, clear_v_i or any port of r_v_i has more than one bit set, while reset_i is not 1/X;
  - print an info message when width_p*els_p >= 64.
- Implementation: no latches, no combinational path from any input to any output.

Test Plan:
- Reset: width_p=8, els_p=4. Assert reset_i for 2 cycles, then read every entry on all ports -> r_data_o=0x00, r_entry_v_o=0, r_v_o=1 one cycle after each read.
- Masked write: write entry 2 with data 0xFF, mask 0xFF; then data 0x00, mask 0x0F; read entry 2 -> 0xF0, r_entry_v_o=1. Entries 0, 1 and 3 stay 0x00 with valid=0.
- Clear/write precedence: write 0xA5 to entry 1, then clear entry 1, then read -> 0xA5 with r_entry_v_o=0. Next, write 0x3C (mask 0xFF) and clear entry 1 in the same cycle, then read -> 0x3C with valid=1.
- Bypass: entry 0 holds 0x11. Write 0x22 (mask 0xFF) and read entry 0 on port 0 in the same cycle -> r_data_o=0x22 with write_bypass_p=1, and 0x11 with write_bypass_p=0. A read the following cycle returns 0x22 in both configurations.
- Multi-port and hold: read_ports_p=2, port 0 reads entry 3 (0x5A) while port 1 reads entry 3 too -> both return 0x5A. Next cycle both ports go zero-hot -> r_v_o=00; data holds 0x5A (hold_read_p=1) or reads 0x00 (hold_read_p=0).
- Reset mid-operation: write 0x77 to entry 0 in the same cycle reset_i=1 -> after reset, a read of entry 0 returns 0x00 with valid=0. A random one-hot traffic run of 1000 cycles checked against a reference model shows no mismatches.

Source files
------------

// File: rtl/bsg_mem_nr1w_one_hot_mask_write_bit_sync.sv
// bsg_mem_nr1w_one_hot_mask_write_bit_sync: one-hot addressed masked-write register file with per-entry valid bits and registered reads
module bsg_mem_nr1w_one_hot_mask_write_bit_sync #(
  parameter int width_p = 8,
  parameter int els_p = 4,
  parameter int read_ports_p = 1,
  parameter bit write_bypass_p = 1'b0,
  parameter bit hold_read_p = 1'b1,
  localparam int safe_els_lp = els_p > 0 ? els_p : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [safe_els_lp-1:0]              w_v_i,
  input  logic [width_p-1:0]                  w_data_i,
  input  logic [width_p-1:0]                  w_mask_i,
  input  logic [safe_els_lp-1:0]              clear_v_i,
  input  logic [read_ports_p*safe_els_lp-1:0] r_v_i,
  output logic [read_ports_p*width_p-1:0]     r_data_o,
  output logic [read_ports_p-1:0]             r_entry_v_o,
  output logic [read_ports_p-1:0]             r_v_o
);
  logic [safe_els_lp-1:0][width_p-1:0] data_q, data_d, src_data;
  logic [safe_els_lp-1:0] valid_q, valid_d, src_valid;
  logic [read_ports_p-1:0][width_p-1:0] rd_data, r_data_q, r_data_d;
  logic [read_ports_p-1:0] rd_valid, r_entry_v_q, r_entry_v_d, r_v_q, r_v_d;
  always_comb begin
    for (int i = 0; i < safe_els_lp; i++) begin
      data_d[i] = els_p == 0 ? '0 : w_v_i[i] ? (data_q[i] & ~w_mask_i) | (w_data_i & w_mask_i) : data_q[i];
      valid_d[i] = els_p != 0 && (w_v_i[i] || (valid_q[i] && !clear_v_i[i]));
    end
  end
  assign src_data = write_bypass_p ? data_d : data_q;
  assign src_valid = write_bypass_p ? valid_d : valid_q;
  always_comb begin
    for (int p = 0; p < read_ports_p; p++) begin
      rd_data[p] = '0;
      rd_valid[p] = 1'b0;
      for (int i = 0; i < safe_els_lp; i++) begin
        rd_data[p] = rd_data[p] | ({width_p{r_v_i[p*safe_els_lp+i]}} & src_data[i]);
        rd_valid[p] = rd_valid[p] | (r_v_i[p*safe_els_lp+i] & src_valid[i]);
      end
      r_v_d[p] = |r_v_i[p*safe_els_lp +: safe_els_lp];
      r_data_d[p] = r_v_d[p] ? rd_data[p] : hold_read_p ? r_data_q[p] : '0;
      r_entry_v_d[p] = r_v_d[p] ? rd_valid[p] : hold_read_p && r_entry_v_q[p];
    end
  end
  always_ff @(posedge clk_i) begin
    data_q <= reset_i ? '0 : data_d;
    valid_q <= reset_i ? '0 : valid_d;
    r_data_q <= reset_i ? '0 : r_data_d;
    r_entry_v_q <= reset_i ? '0 : r_entry_v_d;
    r_v_q <= reset_i ? '0 : r_v_d;
  end
  assign r_data_o = r_data_q;
  assign r_entry_v_o = r_entry_v_q;
  assign r_v_o = r_v_q;
  always_ff @(posedge clk_i) begin
    if (reset_i === 1'b0) begin
      assert ($onehot0(w_v_i)) else $error("w_v_i not one/zero-hot: %b", w_v_i);
      assert ($onehot0(clear_v_i)) else $error("clear_v_i not one/zero-hot: %b", clear_v_i);
      for (int p = 0; p < read_ports_p; p++)
        assert ($onehot0(r_v_i[p*safe_els_lp +: safe_els_lp])) else $error("r_v_i port %0d not one/zero-hot", p);
    end
  end
  if (width_p * els_p >= 64) begin : g_big
    $info("bsg_mem_nr1w_one_hot_mask_write_bit_sync: %0d x %0d bits", els_p, width_p);
  end
endmodule

// File: tb/tb_bsg_mem_nr1w_one_hot_mask_write_bit_sync.sv
// tb_bsg_mem_nr1w_one_hot_mask_write_bit_sync: scoreboard bench for bypass/hold and no-bypass/no-hold configurations
module tb_bsg_mem_nr1w_one_hot_mask_write_bit_sync;
  typedef struct packed {
    logic [15:0] d_a;
    logic [1:0] ev_a;
    logic [1:0] v_a;
    logic [15:0] d_b;
    logic [1:0] ev_b;
    logic [1:0] v_b;
  } out_t;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] w_v, clr;
  logic [7:0] w_data, w_mask;
  logic [7:0] r_v;
  logic [15:0] d_a, d_b;
  logic [1:0] ev_a, ev_b, v_a, v_b;
  logic [7:0] mem [4];
  logic vld [4];
  logic [7:0] hold_d [2];
  logic hold_ev [2];
  out_t exp_q [$];
  out_t obs_q [$];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  bsg_mem_nr1w_one_hot_mask_write_bit_sync #(
    .width_p(8), .els_p(4), .read_ports_p(2), .write_bypass_p(1'b1), .hold_read_p(1'b1)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .w_v_i(w_v), .w_data_i(w_data), .w_mask_i(w_mask),
    .clear_v_i(clr), .r_v_i(r_v), .r_data_o(d_a), .r_entry_v_o(ev_a), .r_v_o(v_a)
  );
  bsg_mem_nr1w_one_hot_mask_write_bit_sync #(
    .width_p(8), .els_p(4), .read_ports_p(2), .write_bypass_p(1'b0), .hold_read_p(1'b0)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .w_v_i(w_v), .w_data_i(w_data), .w_mask_i(w_mask),
    .clear_v_i(clr), .r_v_i(r_v), .r_data_o(d_b), .r_entry_v_o(ev_b), .r_v_o(v_b)
  );
  task automatic cycle(input logic [3:0] wv, input logic [7:0] wd, input logic [7:0] wm,
                       input logic [3:0] cv, input logic [3:0] r0, input logic [3:0] r1, input logic rs);
    out_t e, o;
    logic [3:0] r;
    logic [7:0] post_d;
    logic post_v;
    int k;
    w_v = wv; w_data = wd; w_mask = wm; clr = cv; r_v = {r1, r0}; rst = rs;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      r = p == 0 ? r0 : r1;
      k = -1;
      for (int i = 0; i < 4; i++) if (r[i]) k = i;
      if (rs) begin
        hold_d[p] = 8'h00;
        hold_ev[p] = 1'b0;
      end else if (k >= 0) begin
        post_d = wv[k] ? (mem[k] & ~wm) | (wd & wm) : mem[k];
        post_v = wv[k] ? 1'b1 : cv[k] ? 1'b0 : vld[k];
        e.d_a[p*8 +: 8] = post_d;
        e.ev_a[p] = post_v;
        e.v_a[p] = 1'b1;
        e.d_b[p*8 +: 8] = mem[k];
        e.ev_b[p] = vld[k];
        e.v_b[p] = 1'b1;
        hold_d[p] = post_d;
        hold_ev[p] = post_v;
      end else begin
        e.d_a[p*8 +: 8] = hold_d[p];
        e.ev_a[p] = hold_ev[p];
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.d_a = d_a; o.ev_a = ev_a; o.v_a = v_a;
    o.d_b = d_b; o.ev_b = ev_b; o.v_b = v_b;
    obs_q.push_back(o);
    for (int i = 0; i < 4; i++) begin
      if (rs) begin
        mem[i] = 8'h00;
        vld[i] = 1'b0;
      end else if (wv[i]) begin
        mem[i] = (mem[i] & ~wm) | (wd & wm);
        vld[i] = 1'b1;
      end else if (cv[i]) vld[i] = 1'b0;
    end
  endtask
  function automatic logic [3:0] rand_oh();
    return $urandom_range(0, 4) == 4 ? 4'b0000 : 4'b0001 << $urandom_range(0, 3);
  endfunction
  task automatic test_reset();
    out_t e, o;
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0001 << i, 4'b0001 << i, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL reset: got %h expected %h", o, e); else passed++;
    end
  endtask
  task automatic test_masked_write();
    out_t e, o;
    cycle(4'b0100, 8'hFF, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0100, 8'h00, 8'h0F, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0100, 4'b0001, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b1000, 4'b0010, 1'b0);
    cycle(4'b0001, 8'h5A, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL masked_write: got %h expected %h", o, e); else passed++;
    end
  endtask
  task automatic test_clear_precedence();
    out_t e, o;
    cycle(4'b0010, 8'hA5, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 8'h3C, 8'hFF, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0010, 4'b0010, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 8'h99, 8'hFF, 4'b0100, 4'b0010, 4'b0100, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL clear_precedence: got %h expected %h", o, e); else passed++;
    end
  endtask
  task automatic test_bypass();
    out_t e, o;
    cycle(4'b0001, 8'h11, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0001, 8'h22, 8'hFF, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL bypass: got %h expected %h", o, e); else passed++;
    end
  endtask
  task automatic test_multiport_hold();
    out_t e, o;
    cycle(4'b1000, 8'h5A, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b1000, 4'b1000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL multiport_hold: got %h expected %h", o, e); else passed++;
    end
  endtask
  task automatic test_reset_mid();
    out_t e, o;
    cycle(4'b0001, 8'h77, 8'hFF, 4'b0000, 4'b0001, 4'b0000, 1'b1);
    cycle(4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0001, 4'b0001, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL reset_mid: got %h expected %h", o, e); else passed++;
    end
  endtask
  task automatic test_random();
    out_t e, o;
    for (int n = 0; n < 1000; n++)
      cycle(rand_oh(), 8'($urandom), 8'($urandom), rand_oh(), rand_oh(), rand_oh(), $urandom_range(0, 99) == 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) $display("FAIL random: got %h expected %h", o, e); else passed++;
    end
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'h00;
      vld[i] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      hold_d[p] = 8'h00;
      hold_ev[p] = 1'b0;
    end
    test_reset();
    test_masked_write();
    test_clear_precedence();
    test_bypass();
    test_multiport_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
